// File: rtl/c17_registered.sv
// ISCAS-85 c17 netlist (six 2-input NANDs) with a one-stage registered copy of
// its outputs and a valid flag, for use inside clocked evaluation harnesses.
module c17_registered (
    input  logic clk,
    input  logic rst,
    input  logic n1,
    input  logic n2,
    input  logic n3,
    input  logic n6,
    input  logic n7,
    input  logic in_valid,
    output logic n22,
    output logic n23,
    output logic n22_q,
    output logic n23_q,
    output logic out_valid
);

    // Each internal net is kept as its own NAND so the gate structure stays
    // visible to fault-injection and approximation tools.
    logic w_n10;
    logic w_n11;
    logic w_n16;
    logic w_n19;
    logic w_n22;
    logic w_n23;

    assign w_n10 = ~(n1 & n3);
    assign w_n11 = ~(n3 & n6);
    assign w_n16 = ~(n2 & w_n11);
    assign w_n19 = ~(w_n11 & n7);
    assign w_n22 = ~(w_n10 & w_n16);
    assign w_n23 = ~(w_n16 & w_n19);

    assign n22 = w_n22;
    assign n23 = w_n23;

    logic r_n22;
    logic r_n23;
    logic r_valid;

    // Data holds when no sample is offered; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n22   <= 1'b0;
            r_n23   <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_n22   <= w_n22;
            r_n23   <= w_n23;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign n22_q     = r_n22;
    assign n23_q     = r_n23;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_c17_registered.sv
// Directed and table-driven checks of c17_registered: exhaustive combinational
// sweep, reset, pipelined capture, hold, mid-stream reset and a random stream.
module tb_c17_registered;

    logic clk;
    logic rst;
    logic n1, n2, n3, n6, n7;
    logic in_valid;
    logic n22, n23, n22_q, n23_q, out_valid;

    int checks;
    int errors;

    typedef struct {
        logic [4:0] pi;
        logic [1:0] expOut;
    } vecT;

    vecT vecTable [32];

    c17_registered dut (
        .clk       (clk),
        .rst       (rst),
        .n1        (n1),
        .n2        (n2),
        .n3        (n3),
        .n6        (n6),
        .n7        (n7),
        .in_valid  (in_valid),
        .n22       (n22),
        .n23       (n23),
        .n22_q     (n22_q),
        .n23_q     (n23_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, well away from the capturing edge.
    task automatic applyStimulus(input logic [4:0] pi, input logic valid, input logic rstIn);
        @(negedge clk);
        {n7, n6, n3, n2, n1} = pi;
        in_valid = valid;
        rst = rstIn;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic checkComb(input string name, input logic [1:0] expected);
        checkOutput(name, {1'b0, n23, n22}, {1'b0, expected});
    endtask

    task automatic checkReg(input string name, input logic expValid, input logic [1:0] expQ);
        @(posedge clk);
        #1;
        checkOutput(name, {out_valid, n23_q, n22_q}, {expValid, expQ});
    endtask

    logic [1:0] refQ;
    logic       refValid;
    logic [4:0] rndPi;
    logic       rndValid;

    initial begin
        logic [1:0] expList [32];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        {n7, n6, n3, n2, n1} = 5'b0;

        // Hand-derived truth table, index = {n7,n6,n3,n2,n1}, value = {n23,n22}.
        expList = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11,
                    2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01,
                    2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11,
                    2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 32; i++) begin
            vecTable[i].pi = 5'(i);
            vecTable[i].expOut = expList[i];
        end

        for (int i = 0; i < 32; i++) begin
            applyStimulus(vecTable[i].pi, 1'b0, 1'b1);
            checkComb($sformatf("comb_pi%0d", i), vecTable[i].expOut);
        end

        // Reset dominates in_valid; combinational path unaffected.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(5'b00010, 1'b1, 1'b1);
            checkComb("reset_comb", 2'b11);
            checkReg("reset_reg", 1'b0, 2'b00);
        end

        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkReg("pipe0", 1'b1, 2'b00);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        checkReg("pipe1", 1'b1, 2'b11);
        applyStimulus(5'b10000, 1'b1, 1'b0);
        checkReg("pipe2", 1'b1, 2'b10);

        applyStimulus(5'b00101, 1'b1, 1'b0);
        checkReg("hold_capture", 1'b1, 2'b01);
        applyStimulus(5'b10000, 1'b0, 1'b0);
        checkComb("hold_comb", 2'b10);
        checkReg("hold_reg", 1'b0, 2'b01);
        checkReg("hold_reg2", 1'b0, 2'b01);

        applyStimulus(5'b10000, 1'b1, 1'b0);
        checkReg("mid_pre", 1'b1, 2'b10);
        applyStimulus(5'b00010, 1'b1, 1'b1);
        checkReg("mid_reset", 1'b0, 2'b00);
        applyStimulus(5'b00010, 1'b0, 1'b0);
        checkReg("post_reset_idle", 1'b0, 2'b00);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        checkReg("post_reset_first", 1'b1, 2'b11);

        refQ = 2'b11;
        refValid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            rndPi = 5'($urandom_range(0, 31));
            rndValid = 1'($urandom_range(0, 1));
            applyStimulus(rndPi, rndValid, 1'b0);
            checkComb("rand_comb", vecTable[rndPi].expOut);
            if (rndValid) refQ = vecTable[rndPi].expOut;
            refValid = rndValid;
            checkReg("rand_reg", refValid, refQ);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
